// File: rtl/inverse_row_normalizer.sv
// Row normaliser for the Gauss-Jordan inversion core: buffers the eliminated
// N x 2N augmented matrix, divides each right-half element by its row pivot
// with a sequential restoring divider and streams the N x N inverse out as
// signed Q(OW-FRAC).FRAC words. Singular or upstream-flagged matrices raise
// out_err on every word of that matrix.
//
// state  | meaning
// S_LOAD | accepting the 2N*N augmented-matrix words into the buffer
// S_DIV  | one operand setup cycle, then DW+FRAC restoring-division steps
// S_OUT  | result word presented, waiting for the sink to take it
module inverse_row_normalizer #(
  parameter int N    = 5,
  parameter int DW   = 32,
  parameter int FRAC = 16,
  parameter int OW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  output logic          out_err
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(2 * N);
  localparam int IW = (N > 1) ? $clog2(N * N) : 1;
  // Unsigned dividend magnitude: |a| <= 2^(DW-1), shifted by FRAC, fits in
  // DW+FRAC bits; together with the separately held sign this is the
  // DW+FRAC+1-bit signed range, so a = -2^(DW-1) cannot wrap.
  localparam int QW = DW + FRAC;
  localparam int NW = $clog2(QW + 1);
  // Saturation limits expressed as quotient magnitudes (requires QW > OW).
  localparam logic [QW-1:0] POS_LIM = {{(QW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic [QW-1:0] NEG_LIM = {{(QW-OW){1'b0}}, 1'b1, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {S_LOAD, S_DIV, S_OUT} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] ld_row_q, ld_row_d;
  logic [CW-1:0] ld_col_q, ld_col_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] col_q, col_d;
  logic          err_acc_q, err_acc_d;
  logic          busy_q, busy_d;
  logic          neg_q, neg_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] dsr_q, dsr_d;
  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          out_err_q, out_err_d;

  // Only the pivots and the right half are ever read back; the left-half
  // non-pivot entries are accepted and dropped.
  logic [DW-1:0] piv_mem [N];
  logic [DW-1:0] rhs_mem [N*N];

  logic          wr_piv, wr_rhs;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [DW-1:0] a_val, p_val, a_mag, p_mag;
  logic [DW-1:0] rem_sh;
  logic          ge;
  logic [QW-1:0] q_mag;
  logic [OW-1:0] q_low, q_res;
  logic          ld_pivot, ld_last, last_word;

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;

  // Buffer addressing, operand fetch, one restoring step and result saturation.
  always_comb begin
    wr_idx    = IW'(ld_row_q) * IW'(N) + IW'(ld_col_q) - IW'(N);
    rd_idx    = IW'(row_q) * IW'(N) + IW'(col_q);
    ld_pivot  = (CW'(ld_row_q) == ld_col_q);
    ld_last   = (ld_row_q == RW'(N - 1)) && (ld_col_q == CW'(2 * N - 1));
    last_word = (row_q == RW'(N - 1)) && (col_q == RW'(N - 1));

    a_val = rhs_mem[rd_idx];
    p_val = piv_mem[row_q];
    a_mag = a_val[DW-1] ? (~a_val + DW'(1)) : a_val;
    p_mag = p_val[DW-1] ? (~p_val + DW'(1)) : p_val;

    // rem < divisor <= 2^(DW-1), so the shifted partial remainder still fits
    // in DW bits; the dropped top bit is folded into the compare regardless.
    rem_sh = {rem_q[DW-2:0], dvd_q[QW-1]};
    ge     = rem_q[DW-1] | (rem_sh >= dsr_q);
    q_mag  = {dvd_q[QW-2:0], ge};
    q_low  = q_mag[OW-1:0];

    if (neg_q) begin
      q_res = (q_mag > NEG_LIM) ? {1'b1, {(OW-1){1'b0}}} : (~q_low + OW'(1));
    end else begin
      q_res = (q_mag > POS_LIM) ? {1'b0, {(OW-1){1'b1}}} : q_low;
    end
  end

  // Next-state and register updates for load, divide and output handshake.
  always_comb begin
    state_d     = state_q;
    ld_row_d    = ld_row_q;
    ld_col_d    = ld_col_q;
    row_d       = row_q;
    col_d       = col_q;
    err_acc_d   = err_acc_q;
    busy_d      = busy_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_err_d   = out_err_q;
    wr_piv      = 1'b0;
    wr_rhs      = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          wr_piv = ld_pivot;
          wr_rhs = (ld_col_q >= CW'(N));
          if ((ld_row_q == '0) && (ld_col_q == '0)) begin
            err_acc_d = in_err | (in_data == '0);
          end else if (ld_pivot && (in_data == '0)) begin
            err_acc_d = 1'b1;
          end
          if (ld_last) begin
            ld_row_d = '0;
            ld_col_d = '0;
            row_d    = '0;
            col_d    = '0;
            busy_d   = 1'b0;
            state_d  = S_DIV;
          end else if (ld_col_q == CW'(2 * N - 1)) begin
            ld_col_d = '0;
            ld_row_d = ld_row_q + RW'(1);
          end else begin
            ld_col_d = ld_col_q + CW'(1);
          end
        end
      end

      S_DIV: begin
        if (!busy_q) begin
          if (p_val == '0) begin
            out_data_d  = '0;
            out_err_d   = err_acc_q;
            out_last_d  = last_word;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end else begin
            dvd_d  = {a_mag, {FRAC{1'b0}}};
            rem_d  = '0;
            dsr_d  = p_mag;
            neg_d  = a_val[DW-1] ^ p_val[DW-1];
            cnt_d  = NW'(QW);
            busy_d = 1'b1;
          end
        end else begin
          dvd_d = q_mag;
          rem_d = ge ? (rem_sh - dsr_q) : rem_sh;
          cnt_d = cnt_q - NW'(1);
          if (cnt_q == NW'(1)) begin
            busy_d      = 1'b0;
            out_data_d  = q_res;
            out_err_d   = err_acc_q;
            out_last_d  = last_word;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end
        end
      end

      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_DIV;
            if (col_q == RW'(N - 1)) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + RW'(1);
            end
          end
        end
      end

      default: state_d = S_LOAD;
    endcase
  end

  // Control and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      ld_row_q    <= '0;
      ld_col_q    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      err_acc_q   <= 1'b0;
      busy_q      <= 1'b0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_row_q    <= ld_row_d;
      ld_col_q    <= ld_col_d;
      row_q       <= row_d;
      col_q       <= col_d;
      err_acc_q   <= err_acc_d;
      busy_q      <= busy_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
    end
  end

  // Matrix buffer; contents are don't-care after reset so it has none.
  always_ff @(posedge clk) begin
    if (wr_piv) piv_mem[ld_row_q] <= in_data;
    if (wr_rhs) rhs_mem[wr_idx] <= in_data;
  end

endmodule

// File: tb/tb_inverse_row_normalizer.sv
// Bench for inverse_row_normalizer: drives augmented matrices, collects the
// inverse stream and compares it with a plain-arithmetic reference.
module tb_inverse_row_normalizer;
  localparam int N    = 5;
  localparam int DW   = 32;
  localparam int FRAC = 16;
  localparam int OW   = 32;
  localparam int NO   = N * N;
  localparam int NI   = 2 * N * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_err = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_last, out_err;
  logic [OW-1:0] out_data;

  int n_vec = 0;
  int n_bad = 0;

  int            mat [N][2*N];
  logic [OW-1:0] got_data [NO];
  logic          got_last [NO];
  logic          got_err  [NO];
  int            got_cnt;
  bit            rx_timeout, tx_timeout, held_changed, overlap_seen;
  int            first_lat;
  logic          post_in_ready, post_out_valid;

  always #5 clk = ~clk;

  inverse_row_normalizer #(.N(N), .DW(DW), .FRAC(FRAC), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_err(in_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err)
  );

  // Reference: (a * 2^FRAC) / p truncated toward zero, saturated to OW bits.
  function automatic logic [31:0] ref_word(input int idx);
    int r, c;
    longint num, q;
    r = idx / N;
    c = idx % N;
    if (mat[r][r] == 0) return 32'h0;
    num = longint'(mat[r][N+c]) * 64'sd65536;
    q = num / longint'(mat[r][r]);
    if (q > 64'sh7FFFFFFF) q = 64'sh7FFFFFFF;
    if (q < -64'sh80000000) q = -64'sh80000000;
    return q[31:0];
  endfunction

  function automatic logic ref_err(input bit e);
    logic any0 = e;
    for (int r = 0; r < N; r++) if (mat[r][r] == 0) any0 = 1'b1;
    return any0;
  endfunction

  function automatic int rand_pivot();
    int p;
    case ($urandom_range(0, 2))
      0: p = int'($urandom_range(1, 16));
      1: p = int'($urandom_range(1, 70000));
      default: p = int'($urandom());
    endcase
    if (p == 0) p = 1;
    if ($urandom_range(0, 1) == 1) p = -p;
    return p;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < 2 * N; c++) begin
        if ($urandom_range(0, 1) == 1) mat[r][c] = int'($urandom());
        else mat[r][c] = int'($urandom_range(0, 200000)) - 100000;
      end
      mat[r][r] = rand_pivot();
    end
  endtask

  task automatic send(input int nwords, input bit err, input bit rand_valid);
    int k = 0;
    int guard = 0;
    tx_timeout = 1'b0;
    while (k < nwords) begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        tx_timeout = 1'b1;
        break;
      end
      in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = mat[k / (2 * N)][k % (2 * N)];
      in_err   = (k == 0) ? err : 1'($urandom_range(0, 1));
      if (in_valid && in_ready) k++;
    end
  endtask

  // mode 0: always ready; 1: random ready; 2: 10-cycle stall on word 7.
  task automatic recv(input int mode);
    int cyc = 0;
    int stall = 0;
    logic [OW-1:0] sd;
    logic sl, se;
    got_cnt = 0;
    rx_timeout = 1'b0;
    held_changed = 1'b0;
    overlap_seen = 1'b0;
    first_lat = 0;
    sd = '0; sl = 1'b0; se = 1'b0;
    while (got_cnt < NO) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_err   = 1'b0;
      cyc++;
      if (cyc > 5000) begin
        rx_timeout = 1'b1;
        break;
      end
      if (out_valid && in_ready) overlap_seen = 1'b1;
      if (out_valid && first_lat == 0) first_lat = cyc;
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2 && out_valid && got_cnt == 7 && stall < 10) begin
        if (stall == 0) begin
          sd = out_data; sl = out_last; se = out_err;
        end else if (out_data !== sd || out_last !== sl || out_err !== se) begin
          held_changed = 1'b1;
        end
        stall++;
        out_ready = 1'b0;
      end
      if (out_valid && out_ready) begin
        got_data[got_cnt] = out_data;
        got_last[got_cnt] = out_last;
        got_err[got_cnt]  = out_err;
        got_cnt++;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    post_in_ready  = in_ready;
    post_out_valid = out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 ||
        out_last !== 1'b0 || out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b data=%h last=%b err=%b, required 1 0 0 0 0",
               in_ready, out_valid, out_data, out_last, out_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    logic [31:0] e;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < 2 * N; c++) mat[r][c] = 0;
    for (int r = 0; r < N; r++) begin
      mat[r][r] = 2;
      mat[r][N+r] = 1;
    end
    send(NI, 1'b0, 1'b0);
    recv(0);
    n_vec++;
    if (rx_timeout !== 1'b0 || tx_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL identity_timeout: words=%0d, required %0d", got_cnt, NO);
    end
    n_vec++;
    if (first_lat !== 50) begin
      n_bad++;
      $display("FAIL identity_latency: first valid at cycle %0d, required 50", first_lat);
    end
    for (int i = 0; i < NO; i++) begin
      e = (i / N == i % N) ? 32'h00008000 : 32'h00000000;
      n_vec++;
      if (got_data[i] !== e || got_last[i] !== (i == NO - 1) || got_err[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL identity word %0d: data=%h last=%b err=%b, required %h %b 0",
                 i, got_data[i], got_last[i], got_err[i], e, (i == NO - 1));
      end
    end
    n_vec++;
    if (post_in_ready !== 1'b1 || post_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL identity_return_to_load: in_ready=%b out_valid=%b, required 1 0",
               post_in_ready, post_out_valid);
    end
  endtask

  task automatic test_fraction_signs();
    logic [31:0] lit [4];
    int          pos [4];
    fill_random();
    mat[0][0] = -4; mat[0][N]   = 3;
    mat[1][1] = 2;  mat[1][N]   = 7;  mat[1][N+1] = -7;
    mat[2][2] = 3;  mat[2][N]   = 1;
    lit[0] = 32'hFFFF4000; pos[0] = 0;
    lit[1] = 32'h00038000; pos[1] = 5;
    lit[2] = 32'hFFFC8000; pos[2] = 6;
    lit[3] = 32'h00005555; pos[3] = 10;
    send(NI, 1'b0, 1'b0);
    recv(0);
    for (int j = 0; j < 4; j++) begin
      n_vec++;
      if (got_data[pos[j]] !== lit[j]) begin
        n_bad++;
        $display("FAIL signs word %0d: data=%h, required %h", pos[j], got_data[pos[j]], lit[j]);
      end
    end
    for (int i = 0; i < NO; i++) begin
      n_vec++;
      if (got_data[i] !== ref_word(i) || got_last[i] !== (i == NO - 1) || got_err[i] !== ref_err(1'b0)) begin
        n_bad++;
        $display("FAIL signs_model word %0d: data=%h last=%b err=%b, required %h %b %b",
                 i, got_data[i], got_last[i], got_err[i], ref_word(i), (i == NO - 1), ref_err(1'b0));
      end
    end
  endtask

  task automatic test_saturation();
    fill_random();
    mat[0][0] = 1;  mat[0][N] = 32'h7FFFFFFF; mat[0][N+1] = 32'h80000000;
    mat[1][1] = -1; mat[1][N] = 32'h80000000;
    send(NI, 1'b0, 1'b0);
    recv(0);
    n_vec++;
    if (got_data[0] !== 32'h7FFFFFFF || got_data[1] !== 32'h80000000 || got_data[5] !== 32'h7FFFFFFF) begin
      n_bad++;
      $display("FAIL saturation: words 0,1,5 = %h %h %h, required 7fffffff 80000000 7fffffff",
               got_data[0], got_data[1], got_data[5]);
    end
    for (int i = 0; i < NO; i++) begin
      n_vec++;
      if (got_data[i] !== ref_word(i) || got_err[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL saturation_model word %0d: data=%h err=%b, required %h 0",
                 i, got_data[i], got_err[i], ref_word(i));
      end
    end
  endtask

  task automatic test_singular();
    fill_random();
    mat[2][2] = 0;
    send(NI, 1'b0, 1'b0);
    recv(0);
    for (int i = 0; i < NO; i++) begin
      n_vec++;
      if (got_err[i] !== 1'b1 || (i / N == 2 && got_data[i] !== 32'h0) || got_data[i] !== ref_word(i)) begin
        n_bad++;
        $display("FAIL singular word %0d: data=%h err=%b, required %h 1", i, got_data[i], got_err[i], ref_word(i));
      end
    end
    fill_random();
    send(NI, 1'b0, 1'b0);
    recv(0);
    for (int i = 0; i < NO; i++) begin
      n_vec++;
      if (got_err[i] !== 1'b0 || got_data[i] !== ref_word(i)) begin
        n_bad++;
        $display("FAIL after_singular word %0d: data=%h err=%b, required %h 0", i, got_data[i], got_err[i], ref_word(i));
      end
    end
  endtask

  task automatic test_in_err();
    fill_random();
    send(NI, 1'b1, 1'b0);
    recv(0);
    for (int i = 0; i < NO; i++) begin
      n_vec++;
      if (got_err[i] !== 1'b1 || got_data[i] !== ref_word(i)) begin
        n_bad++;
        $display("FAIL in_err word %0d: data=%h err=%b, required %h 1", i, got_data[i], got_err[i], ref_word(i));
      end
    end
  endtask

  task automatic test_backpressure();
    fill_random();
    send(NI, 1'b0, 1'b1);
    recv(2);
    n_vec++;
    if (held_changed !== 1'b0 || overlap_seen !== 1'b0 || rx_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL backpressure_hold: changed=%b overlap=%b timeout=%b, required 0 0 0",
               held_changed, overlap_seen, rx_timeout);
    end
    for (int i = 0; i < NO; i++) begin
      n_vec++;
      if (got_data[i] !== ref_word(i) || got_last[i] !== (i == NO - 1) || got_err[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL backpressure word %0d: data=%h last=%b err=%b, required %h %b 0",
                 i, got_data[i], got_last[i], got_err[i], ref_word(i), (i == NO - 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit e;
    for (int m = 0; m < 4; m++) begin
      fill_random();
      if ($urandom_range(0, 3) == 0) mat[$urandom_range(0, N - 1)][0] = 0;
      e = ($urandom_range(0, 3) == 0);
      for (int r = 0; r < N; r++) if ($urandom_range(0, 9) == 0) mat[r][r] = 0;
      send(NI, e, 1'b1);
      recv(1);
      n_vec++;
      if (overlap_seen !== 1'b0 || rx_timeout !== 1'b0 || tx_timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_handshake m%0d: overlap=%b timeouts=%b%b, required 0 00",
                 m, overlap_seen, rx_timeout, tx_timeout);
      end
      for (int i = 0; i < NO; i++) begin
        n_vec++;
        if (got_data[i] !== ref_word(i) || got_last[i] !== (i == NO - 1) || got_err[i] !== ref_err(e)) begin
          n_bad++;
          $display("FAIL b2b m%0d word %0d: data=%h last=%b err=%b, required %h %b %b",
                   m, i, got_data[i], got_last[i], got_err[i], ref_word(i), (i == NO - 1), ref_err(e));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int s = 0; s < 2; s++) begin
      fill_random();
      if (s == 0) begin
        send(30, 1'b1, 1'b0);
      end else begin
        send(NI, 1'b1, 1'b0);
        repeat (20) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid s%0d: in_ready=%b out_valid=%b, required 1 0", s, in_ready, out_valid);
      end
      fill_random();
      send(NI, 1'b0, 1'b0);
      recv(0);
      for (int i = 0; i < NO; i++) begin
        n_vec++;
        if (got_data[i] !== ref_word(i) || got_last[i] !== (i == NO - 1) || got_err[i] !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_mid s%0d word %0d: data=%h last=%b err=%b, required %h %b 0",
                   s, i, got_data[i], got_last[i], got_err[i], ref_word(i), (i == NO - 1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_fraction_signs();
    test_saturation();
    test_singular();
    test_in_err();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
